// File: rtl/noc_pkg.sv
// Shared NoC definitions: address width, default flit width, port indices
// and the flit type used by every router block.
package noc_pkg;

  localparam int ADDR_W     = 8;
  localparam int FLIT_W_DEF = 32;

  // Port index; matches the arbiter mux/demux select encoding.
  typedef enum logic [2:0] {
    PORT_N = 3'd0,
    PORT_S = 3'd1,
    PORT_E = 3'd2,
    PORT_W = 3'd3,
    PORT_L = 3'd4
  } port_e;

  typedef logic [FLIT_W_DEF-1:0] flit_t;

endpackage

// File: rtl/noc_fifo_mem.sv
// DEPTH x FLIT_W register file: one synchronous write port and one
// asynchronous read port. Contents are never reset; the queue control
// decides which entries are meaningful.
module noc_fifo_mem #(
  parameter int FLIT_W = 32,
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [PTR_W-1:0]  wr_addr,
  input  logic [FLIT_W-1:0] wr_data,
  input  logic [PTR_W-1:0]  rd_addr,
  output logic [FLIT_W-1:0] rd_data
);

  logic [FLIT_W-1:0] mem [DEPTH];

  // Store the incoming flit at the write pointer.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Head entry is visible without a clock so the queue falls through.
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/router_input_buffer.sv
// Per-direction router input queue. First-word-fall-through FIFO that
// exposes the head flit and its destination address to the arbiter, pops
// on the arbiter read strobe and returns one credit pulse per pop.
module router_input_buffer
  import noc_pkg::*;
#(
  parameter int FLIT_W   = FLIT_W_DEF,
  parameter int DEPTH    = 4,
  parameter int ADDR_LSB = 24
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [FLIT_W-1:0]          flit_i,
  input  logic                       flit_valid_i,
  input  logic                       arb_read_i,
  output logic                       arb_empty_o,
  output logic [ADDR_W-1:0]          arb_address_o,
  output logic [FLIT_W-1:0]          flit_o,
  output logic                       credit_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       overflow_o,
  output logic                       underflow_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             empty;
  logic             full;
  logic             rd_ok;
  logic             wr_ok;
  logic             drop;
  logic             empty_read;
  logic             credit_p1;
  logic             overflow;
  logic             underflow;

  // Accept/reject decisions; full and empty come from the count alone.
  always_comb begin
    empty      = (count == '0);
    full       = (count == FULL_CNT);
    rd_ok      = arb_read_i && !empty;
    // A full queue still takes a flit when the same cycle pops one.
    wr_ok      = flit_valid_i && (!full || rd_ok);
    drop       = flit_valid_i && !wr_ok;
    empty_read = arb_read_i && empty;
  end

  // Occupancy update; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_nxt = count;
    case ({wr_ok, rd_ok})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // Pointers and count; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count_nxt;
    end
  end

  // --- stage p1: credit return, one cycle after each accepted pop ---
  // Reset cancels any pulse in flight; upstream resets its credits too.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credit_p1 <= 1'b0;
    end else begin
      credit_p1 <= rd_ok;
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (drop) begin
        overflow <= 1'b1;
      end
      if (empty_read) begin
        underflow <= 1'b1;
      end
    end
  end

  noc_fifo_mem #(
    .FLIT_W (FLIT_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr),
    .wr_data (flit_i),
    .rd_addr (rd_ptr),
    .rd_data (flit_o)
  );

  assign arb_address_o = flit_o[ADDR_LSB +: ADDR_W];
  assign arb_empty_o   = empty;
  assign count_o       = count;
  assign credit_o      = credit_p1;
  assign overflow_o    = overflow;
  assign underflow_o   = underflow;

endmodule

// File: tb/tb_router_input_buffer.sv
// Bench for router_input_buffer: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a queue model.
module tb_router_input_buffer;

  localparam int FLIT_W   = 32;
  localparam int DEPTH    = 4;
  localparam int ADDR_LSB = 24;
  localparam int CNT_W    = $clog2(DEPTH + 1);

  logic              clk;
  logic              reset;
  logic [FLIT_W-1:0] flit_i;
  logic              flit_valid_i;
  logic              arb_read_i;
  logic              arb_empty_o;
  logic [7:0]        arb_address_o;
  logic [FLIT_W-1:0] flit_o;
  logic              credit_o;
  logic [CNT_W-1:0]  count_o;
  logic              overflow_o;
  logic              underflow_o;

  int checks = 0;
  int errors = 0;

  router_input_buffer #(
    .FLIT_W   (FLIT_W),
    .DEPTH    (DEPTH),
    .ADDR_LSB (ADDR_LSB)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .flit_i        (flit_i),
    .flit_valid_i  (flit_valid_i),
    .arb_read_i    (arb_read_i),
    .arb_empty_o   (arb_empty_o),
    .arb_address_o (arb_address_o),
    .flit_o        (flit_o),
    .credit_o      (credit_o),
    .count_o       (count_o),
    .overflow_o    (overflow_o),
    .underflow_o   (underflow_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: the queue contents plus expected flag/credit state.
  logic [FLIT_W-1:0] mq[$];
  bit m_cred;
  bit m_ovf;
  bit m_unf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_cred = 1'b0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  task automatic model_step(input bit valid, input logic [FLIT_W-1:0] flit, input bit read);
    bit r_ok;
    bit w_ok;
    r_ok = read && (mq.size() != 0);
    w_ok = valid && ((mq.size() < DEPTH) || r_ok);
    if (read && mq.size() == 0) m_unf = 1'b1;
    if (valid && !w_ok) m_ovf = 1'b1;
    if (r_ok) void'(mq.pop_front());
    if (w_ok) mq.push_back(flit);
    m_cred = r_ok;
  endtask

  task automatic check_model(input string tag);
    logic [FLIT_W-1:0] head;
    chk({tag, "_count"}, 32'(count_o), 32'(mq.size()));
    chk({tag, "_empty"}, 32'(arb_empty_o), 32'(mq.size() == 0));
    chk({tag, "_credit"}, 32'(credit_o), 32'(m_cred));
    chk({tag, "_ovf"}, 32'(overflow_o), 32'(m_ovf));
    chk({tag, "_unf"}, 32'(underflow_o), 32'(m_unf));
    if (mq.size() != 0) begin
      head = mq[0];
      chk({tag, "_flit"}, flit_o, head);
      chk({tag, "_addr"}, 32'(arb_address_o), 32'(head[ADDR_LSB +: 8]));
    end
  endtask

  // One clock: drive inputs, advance the model, sample 1 unit after the edge.
  task automatic step(input bit valid, input logic [FLIT_W-1:0] flit, input bit read, input string tag);
    flit_valid_i = valid;
    flit_i       = flit;
    arb_read_i   = read;
    model_step(valid, flit, read);
    @(posedge clk);
    #1;
    flit_valid_i = 1'b0;
    arb_read_i   = 1'b0;
    check_model(tag);
  endtask

  // Reset pulse placed between edges; outputs must clear without a clock.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    model_reset();
    #2;
    check_model(tag);
    reset = 1'b0;
  endtask

  typedef struct {
    bit          rst;
    bit          valid;
    logic [31:0] flit;
    bit          read;
    int          cnt;
    bit          emp;
    bit          cred;
    bit          ovf;
    bit          unf;
    logic [7:0]  addr;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit rst, input bit valid, input logic [31:0] flit, input bit read,
                     input int cnt, input bit emp, input bit cred, input bit ovf, input bit unf,
                     input logic [7:0] addr);
    vec_t v;
    v.rst = rst; v.valid = valid; v.flit = flit; v.read = read;
    v.cnt = cnt; v.emp = emp; v.cred = cred; v.ovf = ovf; v.unf = unf; v.addr = addr;
    tbl.push_back(v);
  endtask

  initial begin
    reset        = 1'b1;
    flit_i       = '0;
    flit_valid_i = 1'b0;
    arb_read_i   = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_empty", 32'(arb_empty_o), 32'd1);
    chk("rst_credit", 32'(credit_o), 32'd0);
    chk("rst_ovf", 32'(overflow_o), 32'd0);
    chk("rst_unf", 32'(underflow_o), 32'd0);
    reset = 1'b0;

    // rst valid flit read | cnt emp cred ovf unf addr
    // Single flit in and out, credit one cycle after the pop edge.
    add(0, 1, 32'hA500_0001, 0, 1, 0, 0, 0, 0, 8'hA5);
    add(0, 0, 32'h0,         1, 0, 1, 1, 0, 0, 8'h00);
    add(0, 0, 32'h0,         0, 0, 1, 0, 0, 0, 8'h00);
    // Fill to full, dropped 5th write, drain in order.
    add(0, 1, 32'h0100_0000, 0, 1, 0, 0, 0, 0, 8'h01);
    add(0, 1, 32'h0200_0000, 0, 2, 0, 0, 0, 0, 8'h01);
    add(0, 1, 32'h0300_0000, 0, 3, 0, 0, 0, 0, 8'h01);
    add(0, 1, 32'h0400_0000, 0, 4, 0, 0, 0, 0, 8'h01);
    add(0, 1, 32'h0500_0000, 0, 4, 0, 0, 1, 0, 8'h01);
    add(0, 0, 32'h0,         1, 3, 0, 1, 1, 0, 8'h02);
    add(0, 0, 32'h0,         1, 2, 0, 1, 1, 0, 8'h03);
    add(0, 0, 32'h0,         1, 1, 0, 1, 1, 0, 8'h04);
    add(0, 0, 32'h0,         1, 0, 1, 1, 1, 0, 8'h00);
    add(0, 0, 32'h0,         0, 0, 1, 0, 1, 0, 8'h00);
    // Full with simultaneous read and write.
    add(1, 0, 32'h0,         0, 0, 1, 0, 0, 0, 8'h00);
    add(0, 1, 32'h0100_0000, 0, 1, 0, 0, 0, 0, 8'h01);
    add(0, 1, 32'h0200_0000, 0, 2, 0, 0, 0, 0, 8'h01);
    add(0, 1, 32'h0300_0000, 0, 3, 0, 0, 0, 0, 8'h01);
    add(0, 1, 32'h0400_0000, 0, 4, 0, 0, 0, 0, 8'h01);
    add(0, 1, 32'h5500_0000, 1, 4, 0, 1, 0, 0, 8'h02);
    add(0, 0, 32'h0,         1, 3, 0, 1, 0, 0, 8'h03);
    add(0, 0, 32'h0,         1, 2, 0, 1, 0, 0, 8'h04);
    add(0, 0, 32'h0,         1, 1, 0, 1, 0, 0, 8'h55);
    add(0, 0, 32'h0,         1, 0, 1, 1, 0, 0, 8'h00);
    add(0, 0, 32'h0,         0, 0, 1, 0, 0, 0, 8'h00);

    for (int i = 0; i < tbl.size(); i++) begin
      string tag;
      tag = $sformatf("v%0d", i);
      if (tbl[i].rst) begin
        do_reset(tag);
      end else begin
        step(tbl[i].valid, tbl[i].flit, tbl[i].read, tag);
      end
      chk({tag, "_t_count"}, 32'(count_o), 32'(tbl[i].cnt));
      chk({tag, "_t_empty"}, 32'(arb_empty_o), 32'(tbl[i].emp));
      chk({tag, "_t_credit"}, 32'(credit_o), 32'(tbl[i].cred));
      chk({tag, "_t_ovf"}, 32'(overflow_o), 32'(tbl[i].ovf));
      chk({tag, "_t_unf"}, 32'(underflow_o), 32'(tbl[i].unf));
      if (!tbl[i].emp) chk({tag, "_t_addr"}, 32'(arb_address_o), 32'(tbl[i].addr));
    end

    // Wrap-around: ten push/pop cycles at occupancy one.
    step(1'b1, 32'h1000_0000, 1'b0, "wrap_first");
    chk("wrap_first_addr", 32'(arb_address_o), 32'h10);
    for (int i = 1; i < 10; i++) begin
      step(1'b1, {8'(8'h10 + i), 24'h00_00A0 + 24'(i)}, 1'b1, $sformatf("wrap%0d", i));
      chk($sformatf("wrap%0d_addr", i), 32'(arb_address_o), 32'h10 + 32'(i));
      chk($sformatf("wrap%0d_count", i), 32'(count_o), 32'd1);
      chk($sformatf("wrap%0d_credit", i), 32'(credit_o), 32'd1);
    end
    step(1'b0, 32'h0, 1'b1, "wrap_last");
    chk("wrap_last_credit", 32'(credit_o), 32'd1);
    chk("wrap_flags", 32'({overflow_o, underflow_o}), 32'd0);

    // Read on an empty queue, then empty read with a write in the same cycle.
    step(1'b0, 32'h0, 1'b1, "under");
    chk("under_flag", 32'(underflow_o), 32'd1);
    chk("under_credit", 32'(credit_o), 32'd0);
    chk("under_count", 32'(count_o), 32'd0);
    step(1'b1, 32'h7700_0000, 1'b1, "under_wr");
    chk("under_wr_count", 32'(count_o), 32'd1);
    chk("under_wr_addr", 32'(arb_address_o), 32'h77);

    // Async reset between edges with count 3 and a credit pending.
    do_reset("ar_pre");
    for (int i = 0; i < 4; i++) step(1'b1, 32'(i + 1) << 24, 1'b0, $sformatf("ar_fill%0d", i));
    step(1'b0, 32'h0, 1'b1, "ar_pop");
    chk("ar_pop_count", 32'(count_o), 32'd3);
    chk("ar_pop_credit", 32'(credit_o), 32'd1);
    step(1'b1, 32'h0900_0000, 1'b1, "ar_ovf_setup");
    step(1'b0, 32'h0, 1'b0, "ar_idle");
    step(1'b1, 32'h0A00_0000, 1'b0, "ar_full");
    step(1'b1, 32'h0B00_0000, 1'b1, "ar_pop2");
    step(1'b0, 32'h0, 1'b1, "ar_pop3");
    chk("ar_pre_count", 32'(count_o), 32'd3);
    chk("ar_pre_credit", 32'(credit_o), 32'd1);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("ar_count", 32'(count_o), 32'd0);
    chk("ar_empty", 32'(arb_empty_o), 32'd1);
    chk("ar_credit", 32'(credit_o), 32'd0);
    chk("ar_flags", 32'({overflow_o, underflow_o}), 32'd0);
    #1;
    reset = 1'b0;
    step(1'b1, 32'hC300_0000, 1'b0, "ar_after");
    chk("ar_after_addr", 32'(arb_address_o), 32'hC3);

    // Randomized traffic against the queue model, with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      bit v;
      bit r;
      v = ($urandom_range(0, 99) < 55);
      r = ($urandom_range(0, 99) < 50);
      if (i % 1000 == 999) begin
        do_reset($sformatf("rnd_rst%0d", i));
      end else begin
        step(v, $urandom, r, $sformatf("rnd%0d", i));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/router_input_buffer.md
Name: router_input_buffer

Overview:
- Per-direction input queue of the NoC router. One instance each for N, S, E, W and L.
- Accepts flits from the upstream link and holds them in a first-word-fall-through FIFO.
- Presents head-of-queue status (empty flag, 8-bit destination address) to the router arbiter and pops on the arbiter's read strobe.
- Returns one credit pulse upstream per popped flit. This closes the credit loop whose far end is the arbiter's credit inputs.

Parameters:
- FLIT_W, 32: flit width in bits.
- DEPTH, 4: FIFO entries. Power of two, at least 2. Equals the credit count granted to upstream at reset.
- ADDR_LSB, 24: bit position of the 8-bit destination address inside the flit. Address field is flit[ADDR_LSB+7:ADDR_LSB]. ADDR_LSB+7 must be no greater than FLIT_W-1.

Ports:
- clk, input, 1: router clock.
- reset, input, 1: asynchronous, active-high reset.
- flit_i, input, FLIT_W: incoming flit from upstream link.
- flit_valid_i, input, 1: flit_i is valid this cycle; write request.
- arb_read_i, input, 1: pop strobe from arbiter (that port's read output).
- arb_empty_o, output, 1: queue empty; drives arbiter empty input.
- arb_address_o, output, 8: destination address of head flit; drives arbiter address input.
- flit_o, output, FLIT_W: head flit, to crossbar mux.
- credit_o, output, 1: one-cycle credit return pulse to upstream.
- count_o, output, $clog2(DEPTH+1): current occupancy.
- overflow_o, output, 1: sticky, set when a write is dropped.
- underflow_o, output, 1: sticky, set when a read hits an empty queue.

Behaviour:
- Reset (async assert, sync deassert by the next clk edge):
  - Pointers = 0, count_o = 0, arb_empty_o = 1.
  - credit_o = 0, overflow_o = 0, underflow_o = 0.
  - Storage contents are don't-care.
  - flit_o and arb_address_o are don't-care while empty; the bench must not check them.
- FWFT timing:
  - flit_o and arb_address_o always reflect the head entry combinationally from storage and rd_ptr.
  - A flit written at edge k is visible on flit_o, with arb_empty_o = 0, after edge k. That is zero bubble cycles.
- Write acceptance (wr_ok): flit_valid_i && (count < DEPTH || rd_ok).
  - A write into a full queue is accepted only if a pop occurs in the same cycle.
- Write drop: flit_valid_i && !wr_ok means the flit is discarded, overflow_o is set, and pointers and count are unchanged.
- Read acceptance (rd_ok): arb_read_i && count != 0.
  - On rd_ok, rd_ptr advances.
  - A read on an empty queue is ignored and sets underflow_o.
  - A write in the same cycle as an empty-queue read is still accepted.
- Simultaneous read and write: count unchanged, both pointers advance.
  - When count = 1, the new flit becomes head after the edge.
- Pointers: log2(DEPTH) bits, natural wrap from DEPTH-1 to 0. Count is held separately; full/empty are decoded from count only.
- arb_empty_o: registered-equivalent, equal to (count == 0) after each edge.
- credit_o: a flop set to rd_ok. It pulses high for exactly one cycle, one cycle after each accepted pop. Back-to-back pops give back-to-back pulses.
- Credit invariant: upstream credits + count_o + in-flight credit pulses = DEPTH.
- Sticky flags clear only on reset.
- Reset mid-operation: all queued flits are lost. A credit_o pulse in flight is cancelled, and upstream is reset alongside to restore DEPTH credits.

Decomposition:
- Shared package noc_pkg holds:
  - ADDR_W = 8 and the default FLIT_W.
  - Port index enum: PORT_N=0, PORT_S=1, PORT_E=2, PORT_W=3, PORT_L=4, 3 bits. This matches the arbiter mux/demux select encoding.
  - Typedef flit_t.
- Sub-module noc_fifo_mem: DEPTH x FLIT_W register file with one write port and one async read port. The pointer/count/credit control stays in router_input_buffer.

Test Plan (DEPTH=4, FLIT_W=32, ADDR_LSB=24):
1. Reset, then single flit: write 0xA5000001 with no read -> after 1 edge, arb_empty_o=0, arb_address_o=0xA5, count_o=1. Pop -> arb_empty_o=1, credit_o high exactly one cycle after the pop edge.
2. Fill to full: write 0x01..., 0x02..., 0x03..., 0x04... -> count_o=4. A 5th write without read -> dropped, overflow_o=1, count_o=4. Drain 4 -> addresses 0x01, 0x02, 0x03, 0x04 in order, 4 credit pulses.
3. Full with simultaneous read and write of 0x55...: accepted, count_o stays 4, overflow_o stays 0. Drain shows 0x02, 0x03, 0x04, 0x55 with 0x01 popped.
4. Wrap-around: 10 push/pop cycles at count=1 with addresses 0x10..0x19 -> each address appears in order, no flag set, 10 credit pulses.
5. arb_read_i on empty -> underflow_o=1, no credit_o, count_o=0.
6. Async reset asserted mid-cycle with count_o=3 and a credit pulse pending -> immediately count_o=0, arb_empty_o=1, credit_o=0, flags cleared.
